// File: rtl/fifo_status_logic_pkg.sv
// fifo_status_logic_pkg
//   Shared definitions for the FIFO status/occupancy logic: FSM state
//   encoding and default geometry. The read/write pointer logic also imports
//   these so that every block agrees on what EMPTY/PARTIAL/FULL mean.
package fifo_status_logic_pkg;

  localparam int DEF_MEM_SIZE = 4;  // FIFO depth in words
  localparam int DEF_PTR      = 3;  // counter/threshold width, 2**PTR > depth

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_status_logic.sv
// fifo_status_logic
//   Occupancy counter and EMPTY/PARTIAL/FULL state machine for a FIFO of
//   MEM_SIZE words. Tracks accepted push/pop requests and reports full,
//   empty, count and threshold-based almost-full/almost-empty flags.
//
//   Optional feature: define FIFO_STATUS_ERR_EN to add the sticky
//   fifo_error output (overflow/underflow), cleared only by reset.
//
// Ports
//   clk             in   clock, rising edge
//   reset           in   asynchronous, active-low reset
//   push            in   request to store one word this cycle
//   pop             in   request to remove one word this cycle
//   th_almost_full  in   [PTR]  almost_full when count >= this
//   th_almost_empty in   [PTR]  almost_empty when count <= this
//   fifo_full       out  registered, count == MEM_SIZE
//   fifo_empty      out  registered, count == 0
//   almost_full     out  combinational compare of fifo_count
//   almost_empty    out  combinational compare of fifo_count
//   fifo_count      out  [PTR] registered occupancy, 0..MEM_SIZE
//   fifo_error      out  sticky error (FIFO_STATUS_ERR_EN only)
module fifo_status_logic
  import fifo_status_logic_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int PTR      = DEF_PTR
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [PTR-1:0] th_almost_full,
  input  logic [PTR-1:0] th_almost_empty,
  output logic           fifo_full,
  output logic           fifo_empty,
  output logic           almost_full,
  output logic           almost_empty,
  output logic [PTR-1:0] fifo_count
`ifdef FIFO_STATUS_ERR_EN
  ,
  output logic           fifo_error
`endif
);

  localparam logic [PTR-1:0] CNT_MAX = PTR'(MEM_SIZE);
  localparam logic [PTR-1:0] CNT_ONE = PTR'(1);

  fifo_state_e    state, state_nxt;
  logic           push_acc, pop_acc;
  logic [PTR-1:0] count_nxt;

  // Acceptance: a push in FULL is only taken when a pop frees a slot in the
  // same cycle; a pop in EMPTY is never taken. Together these keep the
  // counter inside 0..MEM_SIZE without any saturation logic.
  always_comb begin
    push_acc  = push && ((state != FULL) || pop);
    pop_acc   = pop && (state != EMPTY);
    count_nxt = fifo_count;
    if (push_acc && !pop_acc)
      count_nxt = fifo_count + CNT_ONE;
    else if (pop_acc && !push_acc)
      count_nxt = fifo_count - CNT_ONE;

    state_nxt = state;
    case (state)
      EMPTY:   if (count_nxt != '0) state_nxt = PARTIAL;
      PARTIAL: begin
        if (count_nxt == CNT_MAX)  state_nxt = FULL;
        else if (count_nxt == '0)  state_nxt = EMPTY;
      end
      FULL:    if (count_nxt != CNT_MAX) state_nxt = PARTIAL;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Flags are registered from the next state so they move on the same edge
  // as the state and count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      fifo_count <= count_nxt;
      fifo_full  <= (state_nxt == FULL);
      fifo_empty <= (state_nxt == EMPTY);
    end
  end

  assign almost_full  = (fifo_count >= th_almost_full);
  assign almost_empty = (fifo_count <= th_almost_empty);

`ifdef FIFO_STATUS_ERR_EN
  // Overflow: push with no pop while FULL. Underflow: pop with no push while
  // EMPTY. Simultaneous push/pop is never an error.
  logic err_set;
  assign err_set = (push && !pop && (state == FULL)) ||
                   (pop && !push && (state == EMPTY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       fifo_error <= 1'b0;
    else if (err_set) fifo_error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_status_logic.sv
// tb_fifo_status_logic
//   Directed scenarios plus randomized push/pop traffic for fifo_status_logic,
//   checked against an occupancy-count model of the FIFO rules.
//   Honours FIFO_STATUS_ERR_EN to exercise the sticky error output.
module tb_fifo_status_logic;

  localparam int MEM = 4;
  localparam int PTR = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           push, pop;
  logic [PTR-1:0] th_af, th_ae;
  logic           fifo_full, fifo_empty, almost_full, almost_empty;
  logic [PTR-1:0] fifo_count;
`ifdef FIFO_STATUS_ERR_EN
  logic           fifo_error;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: occupancy as an integer plus the sticky error bit.
  int m_count = 0;
  bit m_err   = 0;

  fifo_status_logic #(.MEM_SIZE(MEM), .PTR(PTR)) dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .pop             (pop),
    .th_almost_full  (th_af),
    .th_almost_empty (th_ae),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .fifo_count      (fifo_count)
`ifdef FIFO_STATUS_ERR_EN
    ,
    .fifo_error      (fifo_error)
`endif
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus; model updated at the edge, outputs settle
  // by #1 after it.
  task automatic drive(input logic p, input logic q);
    bit pa, pd;
    @(negedge clk);
    push = p;
    pop  = q;
    @(posedge clk);
    if (reset) begin
      pa = p && (m_count < MEM || q);
      pd = q && (m_count > 0);
      if ((p && !q && m_count == MEM) || (q && !p && m_count == 0)) m_err = 1;
      m_count = m_count + int'(pa) - int'(pd);
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b0;
    m_count = 0;
    m_err   = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    push  = 1'b1;
    pop   = 1'b0;
    m_count = 0;
    m_err   = 0;
    #1;
    checks++;
    if (fifo_count !== 3'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_state count=%0d empty=%b full=%b want 0/1/0",
               fifo_count, fifo_empty, fifo_full);
    end
    // push held across an edge while in reset must be ignored
    @(posedge clk); #1;
    checks++;
    if (fifo_count !== 3'd0 || fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_ignores_push count=%0d empty=%b want 0/1", fifo_count, fifo_empty);
    end
`ifdef FIFO_STATUS_ERR_EN
    checks++;
    if (fifo_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_error got=%b want 0", fifo_error);
    end
`endif
    @(negedge clk);
    push  = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (fifo_count !== PTR'(i) || fifo_full !== (i == 4) || fifo_empty !== 1'b0) begin
        failures++;
        $display("FAIL fill_%0d count=%0d full=%b empty=%b want %0d/%b/0",
                 i, fifo_count, fifo_full, fifo_empty, i, (i == 4));
      end
    end
  endtask

  // Continues from the full FIFO left by test_fill.
  task automatic test_full_push_pop();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      checks++;
      if (fifo_count !== 3'd4 || fifo_full !== 1'b1) begin
        failures++;
        $display("FAIL full_push_pop_%0d count=%0d full=%b want 4/1", i, fifo_count, fifo_full);
      end
`ifdef FIFO_STATUS_ERR_EN
      checks++;
      if (fifo_error !== 1'b0) begin
        failures++;
        $display("FAIL full_push_pop_err_%0d got=%b want 0", i, fifo_error);
      end
`endif
    end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    drive(1'b1, 1'b1);
    checks++;
    if (fifo_count !== 3'd1 || fifo_empty !== 1'b0 || fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL empty_push_pop count=%0d empty=%b full=%b want 1/0/0",
               fifo_count, fifo_empty, fifo_full);
    end
`ifdef FIFO_STATUS_ERR_EN
    checks++;
    if (fifo_error !== 1'b0) begin
      failures++;
      $display("FAIL empty_push_pop_err got=%b want 0", fifo_error);
    end
`endif
  endtask

  task automatic test_thresholds();
    do_reset();
    th_af = 3'd3;
    th_ae = 3'd1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) drive(1'b1, 1'b0);
      else #1;
      checks++;
      if (almost_empty !== (i <= 1) || almost_full !== (i >= 3)) begin
        failures++;
        $display("FAIL thresholds_c%0d ae=%b af=%b want %b/%b",
                 i, almost_empty, almost_full, (i <= 1), (i >= 3));
      end
    end
  endtask

`ifdef FIFO_STATUS_ERR_EN
  task automatic test_overflow_error();
    do_reset();
    repeat (4) drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    checks++;
    if (fifo_error !== 1'b1 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL overflow err=%b count=%0d want 1/4", fifo_error, fifo_count);
    end
    drive(1'b0, 1'b1);
    checks++;
    if (fifo_error !== 1'b1 || fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL overflow_sticky err=%b count=%0d want 1/3", fifo_error, fifo_count);
    end
    do_reset();
    #1;
    checks++;
    if (fifo_error !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear err=%b want 0", fifo_error);
    end
    drive(1'b0, 1'b1);
    checks++;
    if (fifo_error !== 1'b1 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL underflow err=%b count=%0d want 1/0", fifo_error, fifo_count);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    repeat (3) drive(1'b1, 1'b0);
    push = 1'b0;
    // assert reset between edges and look before the next rising edge
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 3'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL async_reset count=%0d empty=%b full=%b want 0/1/0",
               fifo_count, fifo_empty, fifo_full);
    end
    m_count = 0;
    m_err   = 0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0);
    checks++;
    if (fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL async_reset_push count=%0d want 1", fifo_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      th_af = PTR'($urandom_range(0, 7));
      th_ae = PTR'($urandom_range(0, 7));
      // bias phases toward filling or draining so both ends are visited
      if ((i / 40) % 2 == 0)
        drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) == 0));
      else
        drive(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) != 0));
      checks++;
      if (int'(fifo_count) != m_count || fifo_full !== (m_count == MEM) ||
          fifo_empty !== (m_count == 0) ||
          almost_full !== (m_count >= int'(th_af)) ||
          almost_empty !== (m_count <= int'(th_ae))) begin
        failures++;
        $display("FAIL random_%0d count=%0d full=%b empty=%b af=%b ae=%b want count=%0d thaf=%0d thae=%0d",
                 i, fifo_count, fifo_full, fifo_empty, almost_full, almost_empty,
                 m_count, th_af, th_ae);
      end
`ifdef FIFO_STATUS_ERR_EN
      checks++;
      if (fifo_error !== m_err) begin
        failures++;
        $display("FAIL random_err_%0d got=%b want %b", i, fifo_error, m_err);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    th_af = 3'd3;
    th_ae = 3'd1;
    test_reset();
    test_fill();
    test_full_push_pop();
    test_empty_push_pop();
    test_thresholds();
`ifdef FIFO_STATUS_ERR_EN
    test_overflow_error();
`endif
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_status_logic.md
FIFO_STATUS_LOGIC -- requirements
Module: fifo_status_logic

Interface
REQ-001 Parameter MEM_SIZE, default 4, FIFO depth in words; SHALL be at least 2.
REQ-002 Parameter PTR, default 3, counter and threshold width; SHALL satisfy 2**PTR > MEM_SIZE.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 push  input  1  write-side request to store one word this cycle.
REQ-006 pop  input  1  read-side request to remove one word this cycle.
REQ-007 th_almost_full  input  PTR  almost-full threshold, in words.
REQ-008 th_almost_empty  input  PTR  almost-empty threshold, in words.
REQ-009 fifo_full  output  1  high when occupancy equals MEM_SIZE.
REQ-010 fifo_empty  output  1  high when occupancy equals 0.
REQ-011 almost_full  output  1  high when occupancy >= th_almost_full.
REQ-012 almost_empty  output  1  high when occupancy <= th_almost_empty.
REQ-013 fifo_count  output  PTR  current occupancy, 0..MEM_SIZE.
REQ-014 fifo_error  output  1  sticky overflow/underflow flag; present only under FIFO_STATUS_ERR_EN.

Function
REQ-015 State machine SHALL have exactly three states: EMPTY (count 0), PARTIAL (0 < count < MEM_SIZE), FULL (count MEM_SIZE).
REQ-016 Push accepted SHALL mean: push=1 and (state != FULL or pop=1).
REQ-017 Pop accepted SHALL mean: pop=1 and state != EMPTY.
REQ-018 Accepted push only SHALL increment count by 1; accepted pop only SHALL decrement count by 1; both accepted or neither accepted SHALL leave count unchanged.
REQ-019 push=1 and pop=1 in EMPTY SHALL accept the push, ignore the pop, and move to PARTIAL with count 1 (count 1 when MEM_SIZE = 1 is excluded by REQ-001).
REQ-020 push=1 and pop=1 in FULL SHALL accept both; count stays MEM_SIZE and state stays FULL.
REQ-021 Transitions: EMPTY->PARTIAL on net +1; PARTIAL->FULL when next count = MEM_SIZE; PARTIAL->EMPTY when next count = 0; FULL->PARTIAL on net -1; all others hold.
REQ-022 fifo_full, fifo_empty and fifo_count SHALL be registered and change on the same edge that updates the state, with one cycle of latency from push/pop.
REQ-023 almost_full and almost_empty SHALL be combinational compares of registered fifo_count against the current threshold inputs, using unsigned arithmetic at PTR bits.
REQ-024 Count arithmetic SHALL never wrap: no value outside 0..MEM_SIZE is reachable.

Reset
REQ-025 Asserting reset low SHALL immediately force: state EMPTY, fifo_count 0, fifo_empty 1, fifo_full 0, fifo_error 0.
REQ-026 While reset is low, push and pop SHALL be ignored.
REQ-027 Reset asserted mid-operation SHALL discard occupancy; the first edge after release SHALL evaluate from EMPTY.

Configuration
REQ-028 Macro FIFO_STATUS_ERR_EN defined: fifo_error SHALL be set on the edge following push=1 in FULL with pop=0 (overflow), or on the edge following pop=1 in EMPTY with push=0 (underflow); it SHALL clear only on reset.
REQ-029 Macro FIFO_STATUS_ERR_EN undefined: the fifo_error port and its register SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold the state encoding constants (EMPTY=2'd0, PARTIAL=2'd1, FULL=2'd2) and the default MEM_SIZE and PTR values, for reuse by the read and write pointer logic.
REQ-031 The block SHALL be a single module with no sub-modules; the occupancy counter and the FSM SHALL reside in it.

Verification
REQ-032 Reset release, then 4 push cycles (MEM_SIZE=4) -> fifo_count 1,2,3,4; fifo_full=1 on the fourth edge; fifo_empty drops after the first edge.
REQ-033 FULL, push=1 pop=1 for 3 cycles -> count stays 4, fifo_full stays 1, fifo_error stays 0.
REQ-034 EMPTY, push=1 pop=1 -> count 1, state PARTIAL, fifo_error 0.
REQ-035 th_almost_full=3, th_almost_empty=1, fill 0->4 -> almost_empty at counts 0 and 1; almost_full at counts 3 and 4.
REQ-036 With FIFO_STATUS_ERR_EN defined: push in FULL with pop=0 -> fifo_error=1 next edge, count stays 4; error persists through a later pop and clears only on reset.
REQ-037 Reset pulsed low mid-cycle at count 3 -> outputs clear asynchronously, before the next clk edge; a push after release -> count 1.
